// File: rtl/mono_sample_to_packet_converter_pkg.sv
`default_nettype none
// ============================================================================
// mono_sample_to_packet_converter_pkg: shared audio widths and FSM encodings
// Revision: 1.0
// ============================================================================
package mono_sample_to_packet_converter_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int SAMPLE_BITS        = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_L = 2'd1,
    ST_SEND_R = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mono_sample_to_packet_converter.sv
`default_nettype none
// ============================================================================
// mono_sample_to_packet_converter: each mono sample -> 2-beat (L,R) AXIS packet
// Revision: 1.0
// ============================================================================
module mono_sample_to_packet_converter
  import mono_sample_to_packet_converter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  input  logic                  mono_valid,
  output logic                  mono_ready,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    w_in_hs;

  // Ready is forced low in reset so no sample is consumed while the FSM is held.
  assign mono_ready = AXIS_ARESETN &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_SEND_R) && M_AXIS_TREADY));
  assign w_in_hs    = mono_valid && mono_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (w_in_hs) begin
          hold_d  = mono_sample;
          state_d = ST_SEND_L;
        end
      end
      ST_SEND_L: begin
        if (M_AXIS_TREADY) begin
          state_d = ST_SEND_R;
        end
      end
      ST_SEND_R: begin
        if (M_AXIS_TREADY) begin
          if (w_in_hs) begin
            hold_d  = mono_sample;
            state_d = ST_SEND_L;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tvalid_d = (state_d == ST_SEND_L) || (state_d == ST_SEND_R);
    tlast_d  = (state_d == ST_SEND_R);
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign M_AXIS_TDATA  = hold_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_mono_sample_to_packet_converter.sv
`default_nettype none
// ============================================================================
// tb_mono_sample_to_packet_converter: directed vector table plus random stall run
// Revision: 1.0
// ============================================================================
module tb_mono_sample_to_packet_converter;

  localparam int DW         = 32;
  localparam int N_RAND     = 2000;
  localparam int RAND_LIMIT = 40000;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] mono_sample;
  logic          mono_valid;
  logic          mono_ready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mono_sample_to_packet_converter #(.DATA_WIDTH(DW)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rstn),
    .mono_sample   (mono_sample),
    .mono_valid    (mono_valid),
    .mono_ready    (mono_ready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready)
  );

  typedef struct {
    logic          rstn;
    logic          valid;
    logic [DW-1:0] sample;
    logic          tready;
    logic          e_ready;
    logic          e_tvalid;
    logic          e_tlast;
    logic          chk_data;
    logic [DW-1:0] e_tdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [DW-1:0] s, input logic tr,
                     input logic er, input logic ev, input logic el, input logic cd,
                     input logic [DW-1:0] ed);
    vec_t t;
    t.rstn = r; t.valid = v; t.sample = s; t.tready = tr;
    t.e_ready = er; t.e_tvalid = ev; t.e_tlast = el; t.chk_data = cd; t.e_tdata = ed;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] sb[$];
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          prev_stall;
  logic          beat;
  int            accepted;
  int            beats;
  int            cyc;

  initial begin
    rstn        = 1'b0;
    mono_valid  = 1'b1;
    mono_sample = 32'hDEAD_BE00;
    tready      = 1'b1;

    // Reset state, with a valid sample offered that must not be taken
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ready",  {31'd0, mono_ready}, 32'd0);
    check("reset_tvalid", {31'd0, tvalid},     32'd0);
    check("reset_tlast",  {31'd0, tlast},      32'd0);
    check("reset_tdata",  tdata,               32'd0);

    //   rstn v  sample          trdy  rdy tv tl cd  tdata
    // single sample
    add(1, 1, 32'hABCDEF00, 1,    1, 0, 0, 1, 32'h0);
    add(1, 0, 32'h0,        1,    0, 1, 0, 1, 32'hABCDEF00);
    add(1, 0, 32'h0,        1,    1, 1, 1, 1, 32'hABCDEF00);
    add(1, 0, 32'h0,        1,    1, 0, 0, 0, 32'h0);
    // back-to-back samples
    add(1, 1, 32'h00000100, 1,    1, 0, 0, 0, 32'h0);
    add(1, 1, 32'h00000200, 1,    0, 1, 0, 1, 32'h00000100);
    add(1, 1, 32'h00000200, 1,    1, 1, 1, 1, 32'h00000100);
    add(1, 1, 32'h00000300, 1,    0, 1, 0, 1, 32'h00000200);
    add(1, 1, 32'h00000300, 1,    1, 1, 1, 1, 32'h00000200);
    add(1, 0, 32'h0,        1,    0, 1, 0, 1, 32'h00000300);
    add(1, 0, 32'h0,        1,    1, 1, 1, 1, 32'h00000300);
    add(1, 0, 32'h0,        1,    1, 0, 0, 0, 32'h0);
    // stall in SEND_L for 5 cycles, ignored sample on the input
    add(1, 1, 32'h7FFFFF00, 0,    1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++)
      add(1, 1, 32'h11111100, 0,  0, 1, 0, 1, 32'h7FFFFF00);
    add(1, 0, 32'h0,        1,    0, 1, 0, 1, 32'h7FFFFF00);
    add(1, 0, 32'h0,        1,    1, 1, 1, 1, 32'h7FFFFF00);
    add(1, 0, 32'h0,        1,    1, 0, 0, 0, 32'h0);
    // stall in SEND_R with a waiting sample, taken on TREADY rise
    add(1, 1, 32'hAAAA0000, 1,    1, 0, 0, 0, 32'h0);
    add(1, 1, 32'h12345600, 1,    0, 1, 0, 1, 32'hAAAA0000);
    for (int i = 0; i < 3; i++)
      add(1, 1, 32'h12345600, 0,  0, 1, 1, 1, 32'hAAAA0000);
    add(1, 1, 32'h12345600, 1,    1, 1, 1, 1, 32'hAAAA0000);
    add(1, 0, 32'h0,        1,    0, 1, 0, 1, 32'h12345600);
    add(1, 0, 32'h0,        1,    1, 1, 1, 1, 32'h12345600);
    add(1, 0, 32'h0,        1,    1, 0, 0, 0, 32'h0);
    // reset during SEND_R aborts the packet
    add(1, 1, 32'h80000000, 1,    1, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0,        1,    0, 1, 0, 1, 32'h80000000);
    add(0, 0, 32'h0,        1,    0, 1, 1, 1, 32'h80000000);
    add(1, 0, 32'h0,        1,    1, 0, 0, 1, 32'h0);
    add(1, 1, 32'h00000100, 1,    1, 0, 0, 1, 32'h0);
    add(1, 0, 32'h0,        1,    0, 1, 0, 1, 32'h00000100);
    add(1, 0, 32'h0,        1,    1, 1, 1, 1, 32'h00000100);
    add(1, 0, 32'h0,        1,    1, 0, 0, 0, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rstn        = vq[i].rstn;
      mono_valid  = vq[i].valid;
      mono_sample = vq[i].sample;
      tready      = vq[i].tready;
      #1;
      check($sformatf("v%0d_ready", i),  {31'd0, mono_ready}, {31'd0, vq[i].e_ready});
      check($sformatf("v%0d_tvalid", i), {31'd0, tvalid},     {31'd0, vq[i].e_tvalid});
      check($sformatf("v%0d_tlast", i),  {31'd0, tlast},      {31'd0, vq[i].e_tlast});
      if (vq[i].chk_data)
        check($sformatf("v%0d_tdata", i), tdata, vq[i].e_tdata);
    end

    // Random TREADY and mono_valid against a sample scoreboard
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    beat       = 1'b0;
    accepted   = 0;
    beats      = 0;
    cyc        = 0;
    while ((accepted < N_RAND || sb.size() > 0) && cyc < RAND_LIMIT) begin
      @(negedge clk);
      cyc++;
      rstn        = 1'b1;
      mono_valid  = (accepted < N_RAND) ? ($urandom_range(3) != 0) : 1'b0;
      mono_sample = $urandom;
      tready      = $urandom_range(1) == 1;
      #1;
      if (prev_stall) begin
        check("stall_tvalid", {31'd0, tvalid}, 32'd1);
        check("stall_tdata",  tdata, prev_data);
        check("stall_tlast",  {31'd0, tlast}, {31'd0, prev_last});
      end
      if (tvalid && !tlast)
        check("send_l_ready", {31'd0, mono_ready}, 32'd0);
      if (mono_valid && mono_ready) begin
        sb.push_back(mono_sample);
        accepted++;
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_extra_beat: got beat 0x%08h, expected no beat", tdata);
        end else begin
          check("rand_tdata", tdata, sb[0]);
          check("rand_tlast", {31'd0, tlast}, {31'd0, beat});
          if (beat) void'(sb.pop_front());
          beat = ~beat;
          beats++;
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
    check("rand_cycle_budget", (cyc < RAND_LIMIT) ? 32'd1 : 32'd0, 32'd1);
    check("rand_beat_count", beats, 2 * N_RAND);
    check("rand_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
